wr_pntrs_and_full: RTL

Write-side pointer and full-flag logic of the dual-clock FIFO. It runs entirely in the write clock domain. It advances the binary write pointer on accepted writes and publishes a registered Gray write pointer to the read domain. It synchronises the read-side Gray pointer in, then derives full, almost-full, used-words and an overflow error flag.

---
 rtl/wr_pntrs_and_full.sv | 118 +++++++++++
 1 files changed

// File: rtl/wr_pntrs_and_full.sv
// Write-domain pointer, full/almost-full, used-words and overflow logic for a dual-clock FIFO.
// Optional macro WR_PNTRS_OVF_CNT_EN adds an 8-bit saturating dropped-write counter.
module wr_pntrs_and_full #(
  parameter int unsigned AWIDTH          = 3,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned ALMOST_FULL_LVL = 6
) (
  input  logic              wr_clk_i,
  input  logic              aclr_i,
  input  logic              wr_req_i,
  input  logic              ovf_clr_i,
  input  logic [AWIDTH:0]   rd_pntr_gray_i,
  output logic [AWIDTH-1:0] wr_pntr_o,
  output logic [AWIDTH:0]   wr_pntr_gray_rd_o,
  output logic              wr_full_o,
  output logic              wr_almost_full_o,
  output logic [AWIDTH:0]   wr_usedw_o,
`ifdef WR_PNTRS_OVF_CNT_EN
  output logic [7:0]        wr_ovf_cnt_o,
`endif
  output logic              wr_ovf_o
);

  localparam logic [AWIDTH:0] AfullLvl = (AWIDTH+1)'(ALMOST_FULL_LVL);
  // Full when write Gray equals read Gray with its two MSBs inverted.
  localparam logic [AWIDTH:0] FullMask = (AWIDTH+1)'(2'b11) << (AWIDTH - 1);

  logic [AWIDTH:0] wr_bin_q, wr_bin_d;
  logic [AWIDTH:0] wr_gray_q, wr_gray_d;
  logic [AWIDTH:0] usedw_q, usedw_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            ovf_q, ovf_d;
  logic            wr_en, wr_drop;
  logic [AWIDTH:0] rd_sync_q [SYNC_STAGES];
  logic [AWIDTH:0] rd_gray_s, rd_bin_s;

  assign wr_en     = wr_req_i & ~full_q;
  assign wr_drop   = wr_req_i & full_q;
  assign rd_gray_s = rd_sync_q[SYNC_STAGES-1];

  always_comb begin
    rd_bin_s = '0;
    rd_bin_s[AWIDTH] = rd_gray_s[AWIDTH];
    for (int i = int'(AWIDTH) - 1; i >= 0; i--) begin
      rd_bin_s[i] = rd_bin_s[i+1] ^ rd_gray_s[i];
    end
  end

  always_comb begin
    wr_bin_d  = wr_bin_q + {{AWIDTH{1'b0}}, wr_en};
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    full_d    = (wr_gray_d == (rd_gray_s ^ FullMask));
    usedw_d   = wr_bin_d - rd_bin_s;
    afull_d   = (usedw_d >= AfullLvl);
    ovf_d     = ovf_q;
    if (wr_drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge wr_clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        rd_sync_q[i] <= '0;
      end
    end else begin
      rd_sync_q[0] <= rd_pntr_gray_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        rd_sync_q[i] <= rd_sync_q[i-1];
      end
    end
  end

  always_ff @(posedge wr_clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      usedw_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      usedw_q   <= usedw_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef WR_PNTRS_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge wr_clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      ovf_cnt_q <= '0;
    end else if (ovf_clr_i) begin
      ovf_cnt_q <= '0;
    end else if (wr_drop && (ovf_cnt_q != 8'hff)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign wr_ovf_cnt_o = ovf_cnt_q;
`endif

  assign wr_pntr_o         = wr_bin_q[AWIDTH-1:0];
  assign wr_pntr_gray_rd_o = wr_gray_q;
  assign wr_full_o         = full_q;
  assign wr_almost_full_o  = afull_q;
  assign wr_usedw_o        = usedw_q;
  assign wr_ovf_o          = ovf_q;

endmodule
